apb_port_responder: RTL and testbench

APB completer that terminates the APB bus from `apb_master` and converts each transfer into a request/acknowledge handshake on one of four peripheral ports, returning read data, `pready` and `pslverr` to the requester. It is the response-side counterpart of the existing master/slave pair: it services reads and writes towards the ports and carries read data back. A per-transfer timeout bounds every transfer.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_timeout_cnt.sv | 26 ++
 rtl/apb_port_responder.sv | 146 ++++++++++++++
 tb/tb_apb_port_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type, widths and port decode for the APB port responder
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;
  localparam int APB_NPORT  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } apb_state_t;

  // The two address MSBs pick the peripheral port.
  function automatic logic [1:0] port_decode(input logic [APB_ADDR_W-1:0] addr);
    return addr[APB_ADDR_W-1:APB_ADDR_W-2];
  endfunction

  function automatic logic [APB_NPORT-1:0] port_onehot(input logic [1:0] idx);
    return APB_NPORT'(1) << idx;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - saturating wait-cycle counter flagging the last allowed REQ cycle
module apb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_port_responder.sv
// rtl/apb_port_responder.sv - APB completer forwarding each transfer to one of four req/ack ports
module apb_port_responder
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NPORT   = APB_NPORT,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_W-1:0]       paddr,
  input  logic [DATA_W-1:0]       pwdata,
  output logic [DATA_W-1:0]       prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [NPORT-1:0]        port_req,
  output logic                    port_wr,
  output logic [ADDR_W-3:0]       port_addr,
  output logic [DATA_W-1:0]       port_wdata,
  input  logic [NPORT-1:0]        port_ack,
  input  logic [NPORT*DATA_W-1:0] port_rdata
);

  apb_state_t state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] prdata_d;
  logic              pready_d, pslverr_d;
  logic [NPORT-1:0]  port_req_d;
  logic              port_wr_d;
  logic [ADDR_W-3:0] port_addr_d;
  logic [DATA_W-1:0] port_wdata_d;
  logic              cnt_clear, cnt_enable, cnt_expired;
  logic              ack_sel;
  logic [DATA_W-1:0] rdata_sel;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // Only the port latched at SETUP is ever listened to.
  always_comb begin
    ack_sel   = port_ack[idx_q];
    rdata_sel = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (idx_q == 2'(i)) begin
        rdata_sel = port_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      port_req   <= '0;
      port_wr    <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prdata     <= prdata_d;
      pready     <= pready_d;
      pslverr    <= pslverr_d;
      port_req   <= port_req_d;
      port_wr    <= port_wr_d;
      port_addr  <= port_addr_d;
      port_wdata <= port_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prdata_d     = prdata;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    port_req_d   = port_req;
    port_wr_d    = port_wr;
    port_addr_d  = port_addr;
    port_wdata_d = port_wdata;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;

    case (state_q)
      IDLE: begin
        // An ACCESS phase without a preceding SETUP never starts a transfer.
        if (psel && !penable) begin
          idx_d        = port_decode(paddr);
          port_wr_d    = pwrite;
          port_addr_d  = paddr[ADDR_W-3:0];
          port_wdata_d = pwdata;
          port_req_d   = port_onehot(port_decode(paddr));
          cnt_clear    = 1'b1;
          state_d      = REQ;
        end
      end

      REQ: begin
        if (!psel) begin
          port_req_d = '0;
          state_d    = IDLE;
        end else if (ack_sel) begin
          // Ack beats a coincident timeout.
          port_req_d = '0;
          prdata_d   = port_wr ? '0 : rdata_sel;
          pready_d   = 1'b1;
          state_d    = RESP;
        end else if (cnt_expired) begin
          port_req_d = '0;
          prdata_d   = '0;
          pready_d   = 1'b1;
          pslverr_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      RESP: begin
        prdata_d = '0;
        state_d  = IDLE;
      end

      default: begin
        port_req_d = '0;
        prdata_d   = '0;
        state_d    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_port_responder.sv
// tb/tb_apb_port_responder.sv - self-checking bench for apb_port_responder
module tb_apb_port_responder;

  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic [3:0]   port_req;
  logic         port_wr;
  logic [5:0]   port_addr;
  logic [31:0]  port_wdata;
  logic [3:0]   port_ack;
  logic [127:0] port_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_port_responder #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .NPORT   (4),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .port_req   (port_req),
    .port_wr    (port_wr),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_ack   (port_ack),
    .port_rdata (port_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prdata"}, prdata, 32'd0);
    chk({tag, "_pready"}, {31'd0, pready}, 32'd0);
    chk({tag, "_pslverr"}, {31'd0, pslverr}, 32'd0);
    chk({tag, "_req"}, {28'd0, port_req}, 32'd0);
    chk({tag, "_wr"}, {31'd0, port_wr}, 32'd0);
    chk({tag, "_addr"}, {26'd0, port_addr}, 32'd0);
    chk({tag, "_wdata"}, port_wdata, 32'd0);
  endtask

  // Transfer-level model: completion cycle is the ack cycle if it falls in
  // 1..TO, else TO with an error; pready shows one cycle later.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input int ack_at,
                      input logic [3:0] wrong, input int abort_at);
    int          idx;
    int          done;
    bit          acked;
    logic [3:0]  oh;
    logic [31:0] exp_rd;
    idx    = int'(addr[7:6]);
    oh     = 4'b0001 << idx;
    wrong  = wrong & ~oh;
    acked  = (abort_at == 0) && (ack_at >= 1) && (ack_at <= TO);
    done   = acked ? ack_at : TO;
    exp_rd = (acked && !wr) ? port_rdata[idx*32 +: 32] : 32'd0;

    chk({tag, "_idle_pready"}, {31'd0, pready}, 32'd0);
    chk({tag, "_idle_req"}, {28'd0, port_req}, 32'd0);
    psel     = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wd;
    port_ack = wrong;

    for (int n = 1; n <= TO + 2; n++) begin
      tick();
      if (psel) penable = 1'b1;
      if (n == 1) begin
        chk({tag, "_port_wr"}, {31'd0, port_wr}, {31'd0, wr});
        chk({tag, "_port_addr"}, {26'd0, port_addr}, {26'd0, addr[5:0]});
        chk({tag, "_port_wdata"}, port_wdata, wd);
      end
      if (abort_at > 0) begin
        chk({tag, "_abort_req"}, {28'd0, port_req}, (n <= abort_at) ? {28'd0, oh} : 32'd0);
        chk({tag, "_abort_pready"}, {31'd0, pready}, 32'd0);
        if (n == abort_at) begin
          psel    = 1'b0;
          penable = 1'b0;
        end
        if (n == abort_at + 2) break;
      end else begin
        chk({tag, "_req"}, {28'd0, port_req}, (n <= done) ? {28'd0, oh} : 32'd0);
        chk({tag, "_pready"}, {31'd0, pready}, (n == done + 1) ? 32'd1 : 32'd0);
        if (n == done + 1) begin
          chk({tag, "_prdata"}, prdata, exp_rd);
          chk({tag, "_pslverr"}, {31'd0, pslverr}, acked ? 32'd0 : 32'd1);
          port_ack = wrong;
          tick();
          psel    = 1'b0;
          penable = 1'b0;
          chk({tag, "_post_pready"}, {31'd0, pready}, 32'd0);
          chk({tag, "_post_prdata"}, prdata, 32'd0);
          chk({tag, "_post_pslverr"}, {31'd0, pslverr}, 32'd0);
          break;
        end
        port_ack = wrong | ((n == ack_at) ? oh : 4'b0000);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    psel       = 1'b0;
    penable    = 1'b0;
    pwrite     = 1'b0;
    paddr      = 8'h00;
    pwdata     = 32'h0;
    port_ack   = 4'b0000;
    port_rdata = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    port_rdata = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    xfer("rd_p2", 1'b0, 8'h85, 32'hA5A5A5A5, 3, 4'b0000, 0);
    xfer("wr_p0", 1'b1, 8'h10, 32'h12345678, 1, 4'b0000, 0);
    xfer("tmo_p3", 1'b0, 8'hC4, 32'h0, 0, 4'b0000, 0);
    xfer("wrong_ack", 1'b0, 8'h41, 32'h0, 5, 4'b0001, 0);
    xfer("ack_last", 1'b0, 8'h82, 32'h0, TO, 4'b0000, 0);
    xfer("abort", 1'b1, 8'h03, 32'hCAFEF00D, 0, 4'b0000, 2);

    // ACCESS without SETUP must be ignored.
    psel    = 1'b1;
    penable = 1'b1;
    tick();
    tick();
    chk("nosetup_req", {28'd0, port_req}, 32'd0);
    chk("nosetup_pready", {31'd0, pready}, 32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    // Reset at T2 with a read in flight.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h7F;
    pwdata  = 32'h55AA55AA;
    tick();
    penable = 1'b1;
    chk("rst_mid_req", {28'd0, port_req}, 32'h2);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    tick();
    xfer("after_rst", 1'b0, 8'hC9, 32'h0, 2, 4'b0000, 0);

    for (int t = 0; t < 24; t++) begin
      logic [7:0]  a;
      logic [3:0]  w;
      int          ack, abt;
      port_rdata = {$urandom, $urandom, $urandom, $urandom};
      a   = 8'($urandom);
      w   = 4'($urandom);
      ack = $urandom_range(0, 20);
      abt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
      xfer("rand", 1'($urandom), a, $urandom, ack, w, abt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
